nastilite_reg_arbiter: RTL

//  NASTI-Lite slave front end for the DDRx controller configuration/status register space.

---
 rtl/nastilite_pkg.sv | 22 ++
 rtl/nastilite_if.sv | 54 +++++
 rtl/nastilite_hold_reg.sv | 33 +++
 rtl/nastilite_reg_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/nastilite_pkg.sv
// Shared types for the NASTI-Lite register front end: response codes and FSM states.
package nastilite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    RESP = 2'b10
  } state_t;

  // Response returned for an access the register space acknowledged.
  function automatic resp_t ack_resp(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/nastilite_if.sv
// NASTI-Lite channel bundle (AW, W, B, AR, R) with a slave-side modport.
interface nastilite_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [USER_WIDTH-1:0]   w_user;

  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic [USER_WIDTH-1:0]   r_user;

  modport slave (
    input  aw_valid, aw_addr, aw_prot, aw_qos, aw_region, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_user,
    output w_ready,
    output b_valid, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_addr, ar_prot, ar_qos, ar_region, ar_user,
    output ar_ready,
    output r_valid, r_data, r_resp, r_user,
    input  r_ready
  );

endinterface

// File: rtl/nastilite_hold_reg.sv
// One-entry holding register: accepts a beat when empty, keeps it until popped.
// in_ready depends only on local state, so there is no combinational ready path.
module nastilite_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  assign in_ready = en && !full;

  // Capture a beat on handshake; release it when the owner pops.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so ordering here is irrelevant.
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/nastilite_reg_arbiter.sv
// NASTI-Lite slave front end for the controller register space. Buffers one AW, one W
// and one AR beat, arbitrates write vs read round-robin, drives a single-port register
// bus with a bounded wait for reg_ack, and returns the B or R response.
module nastilite_reg_arbiter
  import nastilite_pkg::*;
#(
  parameter int C_NASTI_ADDR_WIDTH = 3,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int NUM_REGS           = 1,
  parameter int TIMEOUT            = 16,
  localparam int STRB_W            = C_NASTI_DATA_WIDTH / 8,
  localparam int IDX_W             = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  nastilite_if.slave                    s,
  output logic                          reg_req,
  output logic                          reg_we,
  output logic [IDX_W-1:0]              reg_idx,
  output logic [C_NASTI_DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_W-1:0]             reg_wstrb,
  input  logic [C_NASTI_DATA_WIDTH-1:0] reg_rdata,
  input  logic                          reg_ack,
  input  logic                          reg_err
);

  localparam int AW    = C_NASTI_ADDR_WIDTH;
  localparam int DW    = C_NASTI_DATA_WIDTH;
  localparam int OFFS  = $clog2(STRB_W);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Elaboration-time parameter sanity.
  if (DW != 32 && DW != 64) begin : g_bad_dw
    $fatal(1, "nastilite_reg_arbiter: C_NASTI_DATA_WIDTH must be 32 or 64");
  end
  if ($bits(s.w_data) != DW || $bits(s.aw_addr) != AW) begin : g_if_mismatch
    $fatal(1, "nastilite_reg_arbiter: parameters differ from the bound interface");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $fatal(1, "nastilite_reg_arbiter: TIMEOUT must be at least 2");
  end

  state_t              state, state_nxt;
  logic                accept_en;
  logic                grant_we;
  logic                pref_write;
  logic [CNT_W-1:0]    cnt;
  resp_t               resp_q;
  logic [DW-1:0]       rdata_q;

  logic                aw_full, w_full, ar_full;
  logic [AW-1:0]       aw_addr_q, ar_addr_q;
  logic [DW-1:0]       w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic                pop_wr, pop_rd;

  logic                wr_elig, rd_elig, pick_write;
  logic [AW-1:0]       acc_addr, word_idx;
  logic                in_range;
  logic                timeout_hit;
  logic                resp_hs;

  // Sideband fields carry no meaning for the register space.
  logic unused_sideband;
  assign unused_sideband = ^{s.aw_prot, s.aw_qos, s.aw_region, s.aw_user,
                             s.ar_prot, s.ar_qos, s.ar_region, s.ar_user, s.w_user};

  nastilite_hold_reg #(.WIDTH(AW)) u_aw (
    .clk(clk), .rst(rst), .en(accept_en),
    .in_valid(s.aw_valid), .in_ready(s.aw_ready), .in_data(s.aw_addr),
    .pop(pop_wr), .full(aw_full), .data(aw_addr_q)
  );

  nastilite_hold_reg #(.WIDTH(DW + STRB_W)) u_w (
    .clk(clk), .rst(rst), .en(accept_en),
    .in_valid(s.w_valid), .in_ready(s.w_ready), .in_data({s.w_strb, s.w_data}),
    .pop(pop_wr), .full(w_full), .data({w_strb_q, w_data_q})
  );

  nastilite_hold_reg #(.WIDTH(AW)) u_ar (
    .clk(clk), .rst(rst), .en(accept_en),
    .in_valid(s.ar_valid), .in_ready(s.ar_ready), .in_data(s.ar_addr),
    .pop(pop_rd), .full(ar_full), .data(ar_addr_q)
  );

  // Arbitration: the preferred side wins only when both are eligible.
  assign wr_elig    = aw_full && w_full;
  assign rd_elig    = ar_full;
  assign pick_write = wr_elig && (!rd_elig || pref_write);

  // Access decode from the granted side's holding register.
  assign acc_addr    = grant_we ? aw_addr_q : ar_addr_q;
  assign word_idx    = acc_addr >> OFFS;
  assign in_range    = 32'(word_idx) < NUM_REGS;
  assign timeout_hit = (cnt == CNT_LAST);

  assign reg_req   = (state == ACC) && in_range;
  assign reg_we    = grant_we;
  assign reg_idx   = IDX_W'(word_idx);
  assign reg_wdata = w_data_q;
  assign reg_wstrb = w_strb_q;

  assign s.b_valid = (state == RESP) && grant_we;
  assign s.r_valid = (state == RESP) && !grant_we;
  assign s.b_resp  = resp_q;
  assign s.r_resp  = resp_q;
  assign s.r_data  = rdata_q;
  assign s.b_user  = '0;
  assign s.r_user  = '0;

  assign resp_hs = grant_we ? (s.b_valid && s.b_ready) : (s.r_valid && s.r_ready);
  assign pop_wr  = resp_hs && grant_we;
  assign pop_rd  = resp_hs && !grant_we;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning the default first means no path leaves state_nxt unassigned, so no latch.
    state_nxt = state;
    case (state)
      IDLE:    if (wr_elig || rd_elig) state_nxt = ACC;
      ACC:     if (!in_range || reg_ack || timeout_hit) state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_en  <= 1'b0;
      grant_we   <= 1'b0;
      pref_write <= 1'b1;
      cnt        <= '0;
      resp_q     <= OKAY;
      rdata_q    <= '0;
    end else begin
      accept_en <= 1'b1;
      case (state)
        IDLE: begin
          if (wr_elig || rd_elig) begin
            grant_we <= pick_write;
            cnt      <= '0;
            if (wr_elig && rd_elig) pref_write <= !pick_write;
          end
        end
        ACC: begin
          if (!in_range) begin
            resp_q  <= DECERR;
            rdata_q <= '0;
          end else if (reg_ack) begin
            resp_q <= ack_resp(reg_err);
            if (!grant_we) rdata_q <= reg_rdata;
          end else if (timeout_hit) begin
            resp_q  <= SLVERR;
            rdata_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
